// File: rtl/auth_request_decoder.sv
// Byte-serial USB Type-C Authentication request decoder: assembles the request,
// validates the header and holds one responder enable until it acks, errors or times out.
module auth_request_decoder #(
  parameter int         MSG_BYTES          = 32,
  parameter int         TIMEOUT_CYCLES     = 255,
  parameter logic [7:0] PROTOCOL_VERSION_P = 8'h01
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  input  logic                   rx_last,
  output logic                   rx_ready,
  output logic [8*MSG_BYTES-1:0] auth_msg_out,
  output logic [7:0]             Param1,
  output logic                   digests_enable,
  output logic                   cert_enable,
  output logic                   challenge_enable,
  input  logic                   Ack_in,
  input  logic                   Error_in,
  output logic                   err_valid,
  output logic [7:0]             err_code,
  output logic                   done,
  output logic [2:0]             o_dbg_state
);
  localparam int MSG_LEN = 8 * MSG_BYTES;
  localparam int CNT_W   = $clog2(MSG_BYTES + 1);
  localparam int TMR_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] CMD_DIGESTS   = 8'h81;
  localparam logic [7:0] CMD_CERT      = 8'h82;
  localparam logic [7:0] CMD_CHALLENGE = 8'h83;
  localparam logic [7:0] ERR_INVALID   = 8'h01;
  localparam logic [7:0] ERR_PROTOCOL  = 8'h02;
  localparam logic [7:0] ERR_UNSPEC    = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RECV     = 3'd1,
    S_DECODE   = 3'd2,
    S_DISPATCH = 3'd3,
    S_ERROR    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE      = 2'd0,
    SEL_DIGESTS   = 2'd1,
    SEL_CERT      = 2'd2,
    SEL_CHALLENGE = 2'd3
  } sel_t;

  state_t             r_state, w_next_state;
  sel_t               r_sel, w_next_sel;
  logic [MSG_LEN-1:0] r_msg;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;
  logic [TMR_W-1:0]   r_timer;
  logic               r_rx_ready;
  logic               r_dig_en, r_cert_en, r_chal_en;
  logic               r_err_valid, r_done;
  logic [7:0]         r_err_code;
  logic [7:0]         w_next_code;
  logic               w_next_done;
  logic               w_accept;
  logic [7:0]         w_version, w_command;

  assign w_accept  = rx_valid && r_rx_ready;
  assign w_version = r_msg[7:0];
  assign w_command = r_msg[15:8];

  // Valid/ready: a byte moves only in a cycle where rx_valid and rx_ready are both high;
  // rx_ready is registered and low outside IDLE/RECV, so upstream simply stalls.
  always_comb begin
    w_next_state = r_state;
    w_next_sel   = r_sel;
    w_next_code  = 8'h00;
    w_next_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = rx_last ? S_DECODE : S_RECV;
      end
      S_RECV: begin
        if (w_accept && rx_last) w_next_state = S_DECODE;
      end
      S_DECODE: begin
        w_next_state = S_ERROR;
        w_next_sel   = SEL_NONE;
        w_next_code  = ERR_INVALID;
        if (r_overflow || (r_count < CNT_W'(4))) begin
          w_next_code = ERR_INVALID;
        end else if (w_version != PROTOCOL_VERSION_P) begin
          w_next_code = ERR_PROTOCOL;
        end else if (w_command == CMD_DIGESTS) begin
          w_next_state = S_DISPATCH;
          w_next_sel   = SEL_DIGESTS;
          w_next_code  = 8'h00;
        end else if (w_command == CMD_CERT) begin
          w_next_state = S_DISPATCH;
          w_next_sel   = SEL_CERT;
          w_next_code  = 8'h00;
        end else if ((w_command == CMD_CHALLENGE) && (r_count == CNT_W'(MSG_BYTES))) begin
          w_next_state = S_DISPATCH;
          w_next_sel   = SEL_CHALLENGE;
          w_next_code  = 8'h00;
        end
      end
      S_DISPATCH: begin
        // Error outranks a simultaneous ack; an ack in the last timer cycle still wins.
        if (Error_in) begin
          w_next_state = S_ERROR;
          w_next_code  = ERR_INVALID;
        end else if (Ack_in) begin
          w_next_state = S_IDLE;
          w_next_done  = 1'b1;
        end else if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          w_next_state = S_ERROR;
          w_next_code  = ERR_UNSPEC;
        end
      end
      S_ERROR: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sel       <= SEL_NONE;
      r_msg       <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_timer     <= '0;
      r_rx_ready  <= 1'b0;
      r_dig_en    <= 1'b0;
      r_cert_en   <= 1'b0;
      r_chal_en   <= 1'b0;
      r_err_valid <= 1'b0;
      r_err_code  <= 8'h00;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_sel       <= w_next_sel;
      r_rx_ready  <= (w_next_state == S_IDLE) || (w_next_state == S_RECV);
      r_dig_en    <= (w_next_state == S_DISPATCH) && (w_next_sel == SEL_DIGESTS);
      r_cert_en   <= (w_next_state == S_DISPATCH) && (w_next_sel == SEL_CERT);
      r_chal_en   <= (w_next_state == S_DISPATCH) && (w_next_sel == SEL_CHALLENGE);
      r_err_valid <= (w_next_state == S_ERROR);
      r_err_code  <= w_next_code;
      r_done      <= w_next_done;

      if ((w_next_state == S_DISPATCH) && (r_state != S_DISPATCH)) begin
        r_timer <= '0;
      end else if (r_state == S_DISPATCH) begin
        r_timer <= r_timer + 1'b1;
      end

      // Bytes past MSG_BYTES are dropped but still consumed until rx_last.
      if (w_accept) begin
        if (r_state == S_IDLE) begin
          r_msg      <= {{(MSG_LEN - 8){1'b0}}, rx_data};
          r_count    <= CNT_W'(1);
          r_overflow <= 1'b0;
        end else if (r_count == CNT_W'(MSG_BYTES)) begin
          r_overflow <= 1'b1;
        end else begin
          for (int i = 0; i < MSG_BYTES; i++) begin
            if (r_count == CNT_W'(i)) r_msg[8*i +: 8] <= rx_data;
          end
          r_count <= r_count + 1'b1;
        end
      end
    end
  end

  assign rx_ready         = r_rx_ready;
  assign auth_msg_out     = r_msg;
  assign Param1           = r_msg[23:16];
  assign digests_enable   = r_dig_en;
  assign cert_enable      = r_cert_en;
  assign challenge_enable = r_chal_en;
  assign err_valid        = r_err_valid;
  assign err_code         = r_err_code;
  assign done             = r_done;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_auth_request_decoder.sv
// Randomized bench for auth_request_decoder: a request-level reference model fills an
// expected-event queue that a negedge monitor drains against err/done/enable activity.
module tb_auth_request_decoder;
  localparam int MSG_BYTES = 32;
  localparam int TIMEOUT   = 255;

  localparam logic [1:0] EV_EN   = 2'd0;
  localparam logic [1:0] EV_DONE = 2'd1;
  localparam logic [1:0] EV_ERR  = 2'd2;

  localparam int M_ACK  = 0;
  localparam int M_ERR  = 1;
  localparam int M_BOTH = 2;
  localparam int M_TMO  = 3;
  localparam int M_RST  = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   rx_valid;
  logic [7:0]             rx_data;
  logic                   rx_last;
  logic                   rx_ready;
  logic [8*MSG_BYTES-1:0] auth_msg_out;
  logic [7:0]             Param1;
  logic                   digests_enable, cert_enable, challenge_enable;
  logic                   Ack_in, Error_in;
  logic                   err_valid;
  logic [7:0]             err_code;
  logic                   done;
  logic [2:0]             dbg_state;

  auth_request_decoder #(
    .MSG_BYTES(MSG_BYTES), .TIMEOUT_CYCLES(TIMEOUT), .PROTOCOL_VERSION_P(8'h01)
  ) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last),
    .rx_ready(rx_ready), .auth_msg_out(auth_msg_out), .Param1(Param1),
    .digests_enable(digests_enable), .cert_enable(cert_enable),
    .challenge_enable(challenge_enable), .Ack_in(Ack_in), .Error_in(Error_in),
    .err_valid(err_valid), .err_code(err_code), .done(done), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // event word: {type[1:0], 6'b0, data[7:0], cycle[31:0]}
  logic [47:0]            exp_q[$];
  logic [8*MSG_BYTES-1:0] exp_msg_q[$];
  logic [7:0]             req_q[$];
  int                     last_cyc;

  // ---------------- reference model ----------------
  // Result: bit 8 = dispatched; [7:0] = enable one-hot {chal,cert,dig} or error code.
  function automatic logic [8:0] model_result();
    int n = req_q.size();
    if (n < 4 || n > MSG_BYTES) return {1'b0, 8'h01};
    if (req_q[0] != 8'h01)      return {1'b0, 8'h02};
    case (req_q[1])
      8'h81:   return {1'b1, 8'h01};
      8'h82:   return {1'b1, 8'h02};
      8'h83:   return (n == MSG_BYTES) ? {1'b1, 8'h04} : {1'b0, 8'h01};
      default: return {1'b0, 8'h01};
    endcase
  endfunction

  function automatic logic [8*MSG_BYTES-1:0] model_msg();
    logic [8*MSG_BYTES-1:0] m = '0;
    for (int i = 0; i < req_q.size() && i < MSG_BYTES; i++) m[8*i +: 8] = req_q[i];
    return m;
  endfunction

  task automatic push_ev(input logic [1:0] typ, input logic [7:0] data, input int at);
    exp_q.push_back({typ, 6'd0, data, 32'(at)});
  endtask

  // ---------------- driver tasks (all entered at a negedge) ----------------
  task automatic build_req(input logic [7:0] ver, input logic [7:0] cmd, input logic [7:0] p1,
                           input logic [7:0] p2, input int len, input bit rand_fill);
    logic [7:0] hdr[4];
    hdr = '{ver, cmd, p1, p2};
    req_q.delete();
    for (int i = 0; i < len; i++)
      req_q.push_back(i < 4 ? hdr[i] : (rand_fill ? 8'($urandom) : 8'hA5));
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    int g = 0;
    rx_valid = 1'b1; rx_data = b; rx_last = last;
    while (!rx_ready && g < 50) begin @(negedge clk); g++; end
    if (!rx_ready) begin
      checks++; errors++;
      $display("FAIL rx_ready_wait: rx_ready=0 after %0d cycles, required 1", g);
    end
    last_cyc = cyc;
    @(negedge clk);
    rx_valid = 1'b0; rx_last = 1'b0;
  endtask

  task automatic reset_check(input string name);
    reset = 1'b1; rx_valid = 1'b0; rx_last = 1'b0; Ack_in = 1'b0; Error_in = 1'b0;
    @(negedge clk);
    checks++;
    if ({rx_ready, digests_enable, cert_enable, challenge_enable, err_valid, done,
         err_code, Param1} !== '0) begin
      errors++;
      $display("FAIL %s_outputs: rdy=%b en=%b%b%b errv=%b done=%b code=%h p1=%h, required all 0",
               name, rx_ready, challenge_enable, cert_enable, digests_enable, err_valid, done,
               err_code, Param1);
    end
    checks++;
    if (auth_msg_out !== '0) begin
      errors++;
      $display("FAIL %s_msg: auth_msg_out=%h, required 0", name, auth_msg_out);
    end
    reset = 1'b0;
    exp_q.delete();
    exp_msg_q.delete();
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: rx_ready=%b one cycle after reset release, required 1",
               name, rx_ready);
    end
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < TIMEOUT + 50) begin @(negedge clk); g++; end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d expected events never seen, required 0", exp_q.size());
      exp_q.delete();
    end
    exp_msg_q.delete();
    @(negedge clk);
  endtask

  task automatic run_request(input int mode, input int delay, input int gap_pct);
    logic [8:0] res;
    int g;
    for (int i = 0; i < req_q.size(); i++) begin
      if ($urandom_range(0, 99) < gap_pct) @(negedge clk);
      send_byte(req_q[i], i == req_q.size() - 1);
    end
    res = model_result();
    if (!res[8]) begin
      push_ev(EV_ERR, res[7:0], last_cyc + 2);
    end else begin
      push_ev(EV_EN, res[7:0], last_cyc + 2);
      exp_msg_q.push_back(model_msg());
      if (mode == M_TMO) begin
        push_ev(EV_ERR, 8'h04, last_cyc + 2 + TIMEOUT);
      end else begin
        g = 0;
        while ({challenge_enable, cert_enable, digests_enable} == 3'b000 && g < 20) begin
          @(negedge clk); g++;
        end
        if (mode == M_RST) begin
          @(negedge clk);
          reset_check("reset_dispatch");
          return;
        end
        repeat (delay) @(negedge clk);
        Ack_in   = (mode == M_ACK) || (mode == M_BOTH);
        Error_in = (mode != M_ACK);
        if (mode == M_ACK) push_ev(EV_DONE, 8'h00, cyc + 1);
        else               push_ev(EV_ERR, 8'h01, cyc + 1);
        @(negedge clk);
        Ack_in = 1'b0; Error_in = 1'b0;
      end
    end
    drain();
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [2:0]             prev_en = 3'b000;
  logic [8*MSG_BYTES-1:0] cur_msg = '0;

  task automatic check_event(input logic [1:0] typ, input logic [7:0] data, input string name);
    logic [47:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event data=%h at cycle %0d, required none", name, data, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e[47:46] != typ || e[39:32] != data || e[31:0] != 32'(cyc)) begin
      errors++;
      $display("FAIL %s: got type=%0d data=%h cycle=%0d, required type=%0d data=%h cycle=%0d",
               name, typ, data, cyc, e[47:46], e[39:32], e[31:0]);
    end
  endtask

  always @(negedge clk) begin
    logic [2:0] en;
    en = {challenge_enable, cert_enable, digests_enable};
    if (!reset) begin
      if ($countones(en) > 1) begin
        checks++; errors++;
        $display("FAIL enable_onehot: enables=%b, required at most one high", en);
      end
      if (en != 3'b000 && prev_en == 3'b000) begin
        check_event(EV_EN, {5'd0, en}, "enable");
        if (exp_msg_q.size() != 0) cur_msg = exp_msg_q.pop_front();
        checks++;
        if (Param1 !== cur_msg[23:16]) begin
          errors++;
          $display("FAIL param1: Param1=%h, required %h", Param1, cur_msg[23:16]);
        end
      end
      if (en != 3'b000) begin
        checks++;
        if (auth_msg_out !== cur_msg || rx_ready !== 1'b0) begin
          errors++;
          $display("FAIL dispatch_hold: rx_ready=%b msg[31:0]=%h, required rx_ready=0 msg[31:0]=%h",
                   rx_ready, auth_msg_out[31:0], cur_msg[31:0]);
        end
      end
      if (done) begin
        check_event(EV_DONE, 8'h00, "done");
        checks++;
        if (en !== 3'b000 || rx_ready !== 1'b1) begin
          errors++;
          $display("FAIL done_release: enables=%b rx_ready=%b, required 000 and 1", en, rx_ready);
        end
      end
      if (err_valid) begin
        check_event(EV_ERR, err_code, "err");
        checks++;
        if (en !== 3'b000) begin
          errors++;
          $display("FAIL err_enables: enables=%b during err_valid, required 000", en);
        end
      end
    end
    prev_en = en;
  end

  // ---------------- stimulus ----------------
  int         r_len, r_mode, r_pick;
  logic [7:0] r_ver, r_cmd;

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rx_last = 1'b0;
    Ack_in = 1'b0; Error_in = 1'b0;
    repeat (2) @(negedge clk);
    reset_check("reset_init");

    // Full CHALLENGE, back-to-back bytes, immediate ack.
    build_req(8'h01, 8'h83, 8'h02, 8'h00, 32, 1'b0);
    run_request(M_ACK, 0, 0);
    // GET_DIGESTS answered with a responder error.
    build_req(8'h01, 8'h81, 8'h00, 8'h00, 4, 1'b0);
    run_request(M_ERR, 1, 0);
    // Bad version, overflow, short CHALLENGE, unknown command, short headers.
    build_req(8'h02, 8'h83, 8'h02, 8'h00, 32, 1'b1); run_request(M_ACK, 0, 0);
    build_req(8'h01, 8'h81, 8'h00, 8'h00, 33, 1'b1); run_request(M_ACK, 0, 0);
    build_req(8'h01, 8'h83, 8'h00, 8'h00, 10, 1'b1); run_request(M_ACK, 0, 0);
    build_req(8'h01, 8'h8F, 8'h00, 8'h00, 4, 1'b0);  run_request(M_ACK, 0, 0);
    build_req(8'h01, 8'h81, 8'h00, 8'h00, 3, 1'b0);  run_request(M_ACK, 0, 0);
    build_req(8'h01, 8'h81, 8'h00, 8'h00, 1, 1'b0);  run_request(M_ACK, 0, 0);
    // Timeout, then simultaneous ack+error.
    build_req(8'h01, 8'h83, 8'h05, 8'h00, 32, 1'b1); run_request(M_TMO, 0, 0);
    build_req(8'h01, 8'h82, 8'h03, 8'h00, 4, 1'b0);  run_request(M_BOTH, 2, 0);

    // Reset mid-RECV at byte 12, then during DISPATCH, then a clean request.
    build_req(8'h01, 8'h83, 8'h01, 8'h00, 32, 1'b1);
    for (int i = 0; i < 12; i++) send_byte(req_q[i], 1'b0);
    reset_check("reset_recv");
    build_req(8'h01, 8'h83, 8'h01, 8'h00, 32, 1'b1); run_request(M_RST, 0, 0);
    build_req(8'h01, 8'h83, 8'h07, 8'h00, 32, 1'b1); run_request(M_ACK, 3, 20);

    for (int t = 0; t < 40; t++) begin
      r_pick = $urandom_range(0, 9);
      case (r_pick)
        0:       r_len = $urandom_range(1, 3);
        1:       r_len = $urandom_range(33, 36);
        2, 3:    r_len = $urandom_range(4, 31);
        default: r_len = 32;
      endcase
      r_ver = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'h01;
      case ($urandom_range(0, 4))
        0:       r_cmd = 8'h81;
        1:       r_cmd = 8'h82;
        2, 3:    r_cmd = 8'h83;
        default: r_cmd = 8'($urandom_range(0, 255));
      endcase
      r_pick = $urandom_range(0, 19);
      r_mode = (r_pick == 0) ? M_TMO : (r_pick < 11) ? M_ACK : (r_pick < 15) ? M_ERR : M_BOTH;
      build_req(r_ver, r_cmd, 8'($urandom), 8'($urandom), r_len, 1'b1);
      run_request(r_mode, $urandom_range(0, 6), 30);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
